// File: rtl/dsp_addsub48.sv
// dsp_addsub48: DSP48E2-style 48-bit registered add/sub ALU, Z +/- (W+X+Y+CIN), carry/borrow cascade.
// Latency 2 cycles at default register depths; ce_i=0 freezes every register (no other backpressure).
module dsp_addsub48 #(
    parameter int          AREG       = 1,
    parameter int          BREG       = 1,
    parameter int          CREG       = 1,
    parameter int          CTRLREG    = 1,
    parameter int          CARRYINREG = 1,
    parameter int          PREG       = 1,
    parameter logic [47:0] RND        = 48'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ce_i,
    input  logic [29:0] a_i,
    input  logic [17:0] b_i,
    input  logic [47:0] c_i,
    input  logic [4:0]  inmode_i,
    input  logic [8:0]  opmode_i,
    input  logic [3:0]  alumode_i,
    input  logic [2:0]  carryinsel_i,
    input  logic        carryin_i,
    input  logic        carrycascin_i,
    output logic [47:0] p_o,
    output logic        carrycascout_o,
    output logic        carryout_o
);

    logic [29:0] r_a1, r_a2;
    logic [17:0] r_b1, r_b2;
    logic [47:0] r_c;
    logic [4:0]  r_inmode;
    logic [8:0]  r_opmode;
    logic [3:0]  r_alumode;
    logic [2:0]  r_carryinsel;
    logic        r_carryin;
    logic [47:0] r_p;
    logic        r_cout;

    logic [29:0] w_a;
    logic [17:0] w_b;
    logic [47:0] w_c;
    logic [4:0]  w_inmode;
    logic [8:0]  w_opmode;
    logic [3:0]  w_alumode;
    logic [2:0]  w_carryinsel;
    logic        w_carryin;
    logic [47:0] w_x, w_y, w_z, w_w;
    logic        w_cin;
    logic [48:0] w_sum;
    logic [48:0] w_z49;
    logic [48:0] w_r;
    logic        w_unused;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a1         <= '0;
            r_a2         <= '0;
            r_b1         <= '0;
            r_b2         <= '0;
            r_c          <= '0;
            r_inmode     <= '0;
            r_opmode     <= '0;
            r_alumode    <= '0;
            r_carryinsel <= '0;
            r_carryin    <= 1'b0;
            r_p          <= '0;
            r_cout       <= 1'b0;
        end else if (ce_i) begin
            r_a1         <= a_i;
            r_a2         <= r_a1;
            r_b1         <= b_i;
            r_b2         <= r_b1;
            r_c          <= c_i;
            r_inmode     <= inmode_i;
            r_opmode     <= opmode_i;
            r_alumode    <= alumode_i;
            r_carryinsel <= carryinsel_i;
            r_carryin    <= carryin_i;
            r_p          <= w_r[47:0];
            r_cout       <= w_r[48];
        end
    end

    assign w_inmode     = (CTRLREG == 0) ? inmode_i     : r_inmode;
    assign w_opmode     = (CTRLREG == 0) ? opmode_i     : r_opmode;
    assign w_alumode    = (CTRLREG == 0) ? alumode_i    : r_alumode;
    assign w_carryinsel = (CTRLREG == 0) ? carryinsel_i : r_carryinsel;
    assign w_carryin    = (CARRYINREG == 0) ? carryin_i : r_carryin;
    assign w_c          = (CREG == 0) ? c_i : r_c;

    // With two-deep A/B, inmode picks the first stage to shorten the path by one cycle.
    assign w_a = (AREG == 0) ? a_i :
                 ((AREG == 1) || w_inmode[0]) ? r_a1 : r_a2;
    assign w_b = (BREG == 0) ? b_i :
                 ((BREG == 1) || w_inmode[4]) ? r_b1 : r_b2;

    assign w_unused = ^w_inmode[3:1];

    always_comb begin
        w_x = '0;
        if (w_opmode[1:0] == 2'b11) w_x = {w_a, w_b};

        w_y = '0;
        case (w_opmode[3:2])
            2'b10:   w_y = '1;
            2'b11:   w_y = w_c;
            default: w_y = '0;
        endcase

        w_z = '0;
        case (w_opmode[6:4])
            3'b010:  w_z = r_p;
            3'b011:  w_z = w_c;
            default: w_z = '0;
        endcase

        w_w = '0;
        case (w_opmode[8:7])
            2'b01:   w_w = r_p;
            2'b10:   w_w = RND;
            2'b11:   w_w = w_c;
            default: w_w = '0;
        endcase

        w_cin = 1'b0;
        case (w_carryinsel)
            3'b000:  w_cin = w_carryin;
            3'b010:  w_cin = carrycascin_i;
            default: w_cin = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, w_w} + {1'b0, w_x} + {1'b0, w_y} + {48'd0, w_cin};
    assign w_z49 = {1'b0, w_z};

    // Bit 48 doubles as borrow on subtracts, so chained slices form wider subtractions.
    always_comb begin
        w_r = '0;
        case (w_alumode)
            4'b0011: w_r = w_z49 - w_sum;
            4'b0001: w_r = w_sum - w_z49 - 49'd1;
            4'b0010: w_r = ~(w_z49 + w_sum);
            default: w_r = w_z49 + w_sum;
        endcase
    end

    assign p_o            = (PREG == 0) ? w_r[47:0] : r_p;
    assign carrycascout_o = (PREG == 0) ? w_r[48]   : r_cout;
    assign carryout_o     = carrycascout_o;

endmodule

// File: tb/tb_dsp_addsub48.sv
// Bench for dsp_addsub48: directed cases plus randomized stream against an arithmetic reference model.
module tb_dsp_addsub48;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] a;
        logic [17:0] b;
        logic [47:0] c;
        logic [4:0]  inm;
        logic [8:0]  op;
        logic [3:0]  alu;
        logic [2:0]  sel;
        logic        cin;
    } rec_t;

    logic        rst, ce;
    rec_t        lo_in, hi_in;
    logic        lo_casc;
    logic [47:0] lo_p, hi_p, a2_p;
    logic        lo_cc, lo_co, hi_cc, hi_co, a2_cc, a2_co;

    dsp_addsub48 u_lo (
        .clk_i(clk), .rst_i(rst), .ce_i(ce),
        .a_i(lo_in.a), .b_i(lo_in.b), .c_i(lo_in.c), .inmode_i(lo_in.inm),
        .opmode_i(lo_in.op), .alumode_i(lo_in.alu), .carryinsel_i(lo_in.sel),
        .carryin_i(lo_in.cin), .carrycascin_i(lo_casc),
        .p_o(lo_p), .carrycascout_o(lo_cc), .carryout_o(lo_co)
    );

    dsp_addsub48 u_hi (
        .clk_i(clk), .rst_i(rst), .ce_i(ce),
        .a_i(hi_in.a), .b_i(hi_in.b), .c_i(hi_in.c), .inmode_i(hi_in.inm),
        .opmode_i(hi_in.op), .alumode_i(hi_in.alu), .carryinsel_i(hi_in.sel),
        .carryin_i(hi_in.cin), .carrycascin_i(lo_cc),
        .p_o(hi_p), .carrycascout_o(hi_cc), .carryout_o(hi_co)
    );

    dsp_addsub48 #(.AREG(2)) u_a2 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce),
        .a_i(lo_in.a), .b_i(lo_in.b), .c_i(lo_in.c), .inmode_i(lo_in.inm),
        .opmode_i(lo_in.op), .alumode_i(lo_in.alu), .carryinsel_i(lo_in.sel),
        .carryin_i(lo_in.cin), .carrycascin_i(lo_casc),
        .p_o(a2_p), .carrycascout_o(a2_cc), .carryout_o(a2_co)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference state: operands captured by the input stage, and the visible result.
    rec_t        m_s1;
    logic [47:0] m_p;
    logic        m_co;

    function automatic logic [48:0] ref_alu(input rec_t s, input logic casc, input logic [47:0] p);
        logic [50:0] x, y, z, w, cin, sum, r;
        x = (s.op[1:0] == 2'b11) ? {3'b0, s.a, s.b} : 51'd0;
        case (s.op[3:2])
            2'b10:   y = {3'b0, {48{1'b1}}};
            2'b11:   y = {3'b0, s.c};
            default: y = 51'd0;
        endcase
        case (s.op[6:4])
            3'b010:  z = {3'b0, p};
            3'b011:  z = {3'b0, s.c};
            default: z = 51'd0;
        endcase
        case (s.op[8:7])
            2'b01:   w = {3'b0, p};
            2'b10:   w = 51'd0;
            2'b11:   w = {3'b0, s.c};
            default: w = 51'd0;
        endcase
        case (s.sel)
            3'b000:  cin = {50'd0, s.cin};
            3'b010:  cin = {50'd0, casc};
            default: cin = 51'd0;
        endcase
        sum = w + x + y + cin;
        case (s.alu)
            4'b0011: r = z - sum;
            4'b0001: r = sum - z - 51'd1;
            4'b0010: r = -(z + sum) - 51'd1;
            default: r = z + sum;
        endcase
        return r[48:0];
    endfunction

    task automatic tick();
        logic [48:0] r;
        r = ref_alu(m_s1, lo_casc, m_p);
        @(posedge clk);
        if (rst) begin
            m_s1 = '0;
            m_p  = '0;
            m_co = 1'b0;
        end else if (ce) begin
            m_p  = r[47:0];
            m_co = r[48];
            m_s1 = lo_in;
        end
        #1;
        chk("model_p", 64'(lo_p), 64'(m_p));
        chk("model_cascout", 64'(lo_cc), 64'(m_co));
        chk("model_carryout", 64'(lo_co), 64'(m_co));
    endtask

    task automatic set_lo(input logic [29:0] a, input logic [17:0] b, input logic [47:0] c,
                          input logic [8:0] op, input logic [3:0] alu, input logic [2:0] sel);
        lo_in.a   = a;
        lo_in.b   = b;
        lo_in.c   = c;
        lo_in.inm = 5'd0;
        lo_in.op  = op;
        lo_in.alu = alu;
        lo_in.sel = sel;
        lo_in.cin = 1'b0;
    endtask

    initial begin
        logic [31:0] r0, r1, r2;
        rst = 1'b1;
        ce = 1'b1;
        lo_in = '0;
        hi_in = '0;
        lo_casc = 1'b0;
        m_s1 = '0;
        m_p = '0;
        m_co = 1'b0;

        @(negedge clk);
        tick();
        chk("reset_p", 64'(lo_p), 64'h0);
        chk("reset_cout", 64'(lo_cc), 64'h0);
        chk("reset_hi_p", 64'(hi_p), 64'h0);
        rst = 1'b0;
        tick();
        chk("post_reset_idle_p", 64'(lo_p), 64'h0);

        set_lo(30'd0, 18'd5, 48'h10, 9'h033, 4'b0000, 3'b000);
        tick(); tick();
        chk("add_p", 64'(lo_p), 64'h15);
        chk("add_cout", 64'(lo_cc), 64'h0);

        set_lo(30'd0, 18'h20, 48'h10, 9'h033, 4'b0011, 3'b000);
        tick(); tick();
        chk("sub_p", 64'(lo_p), 64'hFFFF_FFFF_FFF0);
        chk("sub_borrow", 64'(lo_cc), 64'h1);

        set_lo(30'd0, 18'h20, 48'h10, 9'h030, 4'b0011, 3'b000);
        tick(); tick();
        chk("nop_p", 64'(lo_p), 64'h10);
        chk("nop_cout", 64'(lo_cc), 64'h0);

        // Two-word subtract: upper slice fed one cycle after the lower one.
        set_lo(30'd0, 18'd1, 48'h0, 9'h033, 4'b0011, 3'b000);
        tick();
        hi_in = '{a: 30'd0, b: 18'd0, c: 48'd5, inm: 5'd0, op: 9'h033, alu: 4'b0011, sel: 3'b010, cin: 1'b0};
        tick();
        chk("casc_lo_p", 64'(lo_p), 64'hFFFF_FFFF_FFFF);
        chk("casc_lo_borrow", 64'(lo_cc), 64'h1);
        tick();
        chk("casc_hi_p", 64'(hi_p), 64'h4);
        chk("casc_hi_borrow", 64'(hi_cc), 64'h0);
        hi_in = '0;

        set_lo(30'd0, 18'd3, 48'h10, 9'h033, 4'b0000, 3'b000);
        tick(); tick();
        chk("stream_p", 64'(lo_p), 64'h13);
        rst = 1'b1;
        set_lo(30'd0, 18'd7, 48'h10, 9'h033, 4'b0000, 3'b000);
        tick();
        chk("rst_mid_p0", 64'(lo_p), 64'h0);
        rst = 1'b0;
        tick();
        chk("rst_mid_p1", 64'(lo_p), 64'h0);
        tick();
        chk("rst_resume_p", 64'(lo_p), 64'h17);

        ce = 1'b0;
        set_lo(30'd0, 18'd9, 48'h20, 9'h033, 4'b0000, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ce_hold_p", 64'(lo_p), 64'h17);
        end
        ce = 1'b1;
        tick(); tick();
        chk("ce_resume_p", 64'(lo_p), 64'h29);

        set_lo(30'd0, 18'd0, 48'h10, 9'h033, 4'b0000, 3'b000);
        tick(); tick(); tick();
        chk("areg2_base", 64'(a2_p), 64'h10);
        lo_in.a = 30'd1;
        tick();
        chk("areg2_lat1", 64'(a2_p), 64'h10);
        tick();
        chk("areg1_lat2", 64'(lo_p), 64'h4_0010);
        chk("areg2_lat2", 64'(a2_p), 64'h10);
        tick();
        chk("areg2_lat3", 64'(a2_p), 64'h4_0010);
        lo_in.a = 30'd2;
        lo_in.inm = 5'b00001;
        tick(); tick();
        chk("areg2_a1_sel", 64'(a2_p), 64'h8_0010);

        for (int i = 0; i < 400; i++) begin
            r0 = $urandom; r1 = $urandom; r2 = $urandom;
            rst = ($urandom_range(0, 39) == 0);
            ce  = ($urandom_range(0, 7) != 0);
            lo_in.a   = r0[29:0];
            lo_in.b   = r1[17:0];
            lo_in.c   = ($urandom_range(0, 3) == 0) ? 48'hFFFF_FFFF_FFFF : {r1[31:16], r2};
            lo_in.inm = r0[4:0];
            lo_in.op  = r2[8:0];
            case ($urandom_range(0, 4))
                0: lo_in.alu = 4'b0000;
                1: lo_in.alu = 4'b0011;
                2: lo_in.alu = 4'b0001;
                3: lo_in.alu = 4'b0010;
                default: lo_in.alu = r2[12:9];
            endcase
            case ($urandom_range(0, 2))
                0: lo_in.sel = 3'b000;
                1: lo_in.sel = 3'b010;
                default: lo_in.sel = r2[15:13];
            endcase
            lo_in.cin = r0[30];
            lo_casc   = r0[31];
            tick();
        end
        rst = 1'b0;
        ce = 1'b1;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
